// File: rtl/ctrl_seq_unit_pkg.sv
// Shared constants for the control sequencer: memory opcodes and one-hot phase encodings.
// Memory-class opcodes extend the existing ALU operation map.
package ctrl_seq_unit_pkg;

  localparam logic [3:0] OP_WRITE   = 4'hA;
  localparam logic [3:0] OP_READ    = 4'hB;
  localparam logic [3:0] OP_SPECIAL = 4'hE;
  localparam logic [3:0] OP_STACK   = 4'hF;

  // SPECIAL sub-operation that performs a memory read
  localparam logic [2:0] SPECIAL_RD_SUBOP = 3'b100;

  typedef enum logic [8:0] {
    ST_FETCH     = 9'h001,
    ST_DECODE    = 9'h002,
    ST_REG_READ  = 9'h004,
    ST_EXECUTE   = 9'h008,
    ST_MEM       = 9'h010,
    ST_REG_WRITE = 9'h020,
    ST_IRQ_FETCH = 9'h040,
    ST_IRQ_SAVE  = 9'h080,
    ST_ISR_ENTER = 9'h100
  } state_e;

  // Phases in which an outstanding memory access can be waited on
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/ctrl_seq_unit_irq_prio_enc.sv
// Fixed-priority encoder for masked interrupt requests; the lowest set index wins.
module irq_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the last hit, the lowest index, is the one kept
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ctrl_seq_unit.sv
// Multi-cycle control sequencer driving one-hot pipeline phases, memory strobes and IRQ entry.
// Build option: CTRL_SEQ_TIMEOUT_EN adds a memory-wait timeout with a bus error strobe.
module ctrl_seq_unit
  import ctrl_seq_unit_pkg::*;
#(
  parameter int INSTR_W       = 16,
  parameter int NUM_IRQ       = 4,
  parameter int IRQ_ACK_LAT   = 2,
  parameter int STACK_DIR_BIT = 8,
  parameter int MEM_TIMEOUT   = 255,
  localparam int IRQ_W        = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               I_clk,
  input  logic               I_reset_n,
  input  logic [INSTR_W-1:0] I_instruction,
  input  logic               I_mem_ready,
  input  logic               I_data_ready,
  input  logic               I_irq_enabled,
  input  logic [NUM_IRQ-1:0] I_irq_req,
  input  logic [NUM_IRQ-1:0] I_irq_mask,
  output logic [8:0]         O_state,
  output logic               O_execute,
  output logic               O_push_pc,
  output logic [NUM_IRQ-1:0] O_irq_ack,
  output logic [IRQ_W-1:0]   O_irq_num,
  output logic [INSTR_W-1:0] O_instr,
  output logic               O_bus_err
);

  localparam int LAT_W = (IRQ_ACK_LAT > 1) ? $clog2(IRQ_ACK_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(IRQ_ACK_LAT - 1);

  state_e               state_q, state_d;
  logic                 mem_wait_q, mem_wait_d;
  logic                 save_pc_q, save_pc_d;
  logic                 exec_q, exec_d;
  logic                 push_q, push_d;
  logic [NUM_IRQ-1:0]   ack_q, ack_d;
  logic [IRQ_W-1:0]     num_q, num_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;

  logic [3:0]           opcode;
  logic                 is_read, is_write;
  logic                 mem_complete;
  logic                 irq_valid;
  logic [IRQ_W-1:0]     irq_idx;

`ifdef CTRL_SEQ_TIMEOUT_EN
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                 err_q, err_d;
`endif

  // Memory class always comes from the instruction latched in DECODE
  assign opcode   = instr_q[INSTR_W-1 -: 4];
  assign is_read  = (opcode == OP_READ)
                  || ((opcode == OP_SPECIAL) && (instr_q[2:0] == SPECIAL_RD_SUBOP))
                  || ((opcode == OP_STACK) && instr_q[STACK_DIR_BIT]);
  assign is_write = (opcode == OP_WRITE)
                  || ((opcode == OP_STACK) && !instr_q[STACK_DIR_BIT]);

  // A MEM access cannot complete in the cycle its strobe is on the bus
  assign mem_complete = mem_wait_q &&
    (((state_q == ST_FETCH) && I_data_ready) ||
     ((state_q == ST_MEM) && !exec_q && (is_write ? I_mem_ready : I_data_ready)));

  irq_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IRQ_W)
  ) u_irq_prio_enc (
    .req   (I_irq_req & I_irq_mask),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  always_comb begin
    state_d    = state_q;
    mem_wait_d = mem_wait_q;
    save_pc_d  = save_pc_q;
    exec_d     = 1'b0;
    push_d     = push_q;
    ack_d      = '0;
    num_d      = num_q;
    instr_d    = instr_q;
    lat_cnt_d  = lat_cnt_q;

    case (state_q)
      ST_FETCH: begin
        if (!mem_wait_q) begin
          if (I_mem_ready) begin
            exec_d     = 1'b1;
            mem_wait_d = 1'b1;
          end
        end else if (mem_complete) begin
          mem_wait_d = 1'b0;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        instr_d = I_instruction;
        state_d = ST_REG_READ;
      end
      ST_REG_READ: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (is_read || is_write) begin
          if (I_mem_ready && !mem_wait_q) begin
            exec_d     = 1'b1;
            mem_wait_d = 1'b1;
          end
          state_d = ST_MEM;
        end else begin
          state_d = ST_REG_WRITE;
        end
      end
      ST_MEM: begin
        if (!mem_wait_q) begin
          if (I_mem_ready) begin
            exec_d     = 1'b1;
            mem_wait_d = 1'b1;
          end
        end else if (mem_complete) begin
          mem_wait_d = 1'b0;
          state_d    = ST_REG_WRITE;
        end
      end
      ST_REG_WRITE: begin
        // Finishing the PC save pass takes precedence, so IRQs never nest inside it
        if (save_pc_q) begin
          save_pc_d = 1'b0;
          push_d    = 1'b0;
          state_d   = ST_ISR_ENTER;
        end else if (I_irq_enabled && irq_valid) begin
          num_d          = irq_idx;
          ack_d[irq_idx] = 1'b1;
          lat_cnt_d      = '0;
          state_d        = ST_IRQ_FETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_IRQ_FETCH: begin
        if (lat_cnt_q == LAT_LAST) begin
          lat_cnt_d = '0;
          state_d   = ST_IRQ_SAVE;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      ST_IRQ_SAVE: begin
        // The PC push then runs through the ordinary decode/execute path
        save_pc_d = 1'b1;
        push_d    = 1'b1;
        state_d   = ST_DECODE;
      end
      ST_ISR_ENTER: state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase

`ifdef CTRL_SEQ_TIMEOUT_EN
    err_d      = 1'b0;
    wait_cnt_d = '0;
    if (mem_wait_q && is_wait_state(state_q)) begin
      // A completion landing on the timeout cycle wins over the error
      if (!mem_complete && (wait_cnt_q == WAIT_LAST)) begin
        err_d      = 1'b1;
        mem_wait_d = 1'b0;
        state_d    = ST_FETCH;
      end else begin
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      state_q    <= ST_FETCH;
      mem_wait_q <= 1'b0;
      save_pc_q  <= 1'b0;
      exec_q     <= 1'b0;
      push_q     <= 1'b0;
      ack_q      <= '0;
      num_q      <= '0;
      instr_q    <= '0;
      lat_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_wait_q <= mem_wait_d;
      save_pc_q  <= save_pc_d;
      exec_q     <= exec_d;
      push_q     <= push_d;
      ack_q      <= ack_d;
      num_q      <= num_d;
      instr_q    <= instr_d;
      lat_cnt_q  <= lat_cnt_d;
    end
  end

`ifdef CTRL_SEQ_TIMEOUT_EN
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign O_bus_err = err_q;
`else
  // Timeout compiled out: constant-false, parameter kept so configurations stay interchangeable
  assign O_bus_err = (MEM_TIMEOUT < 0);
`endif

  assign O_state   = state_q;
  assign O_execute = exec_q;
  assign O_push_pc = push_q;
  assign O_irq_ack = ack_q;
  assign O_irq_num = num_q;
  assign O_instr   = instr_q;

endmodule

// File: tb/tb_ctrl_seq_unit.sv
// Directed testbench for ctrl_seq_unit: per-cycle expected outputs go through a scoreboard queue.
module tb_ctrl_seq_unit;
  import ctrl_seq_unit_pkg::*;

  localparam int OBS_W = 18;
  localparam logic [15:0] INS_ADD     = 16'h0123;
  localparam logic [15:0] INS_READ    = {OP_READ, 12'h456};
  localparam logic [15:0] INS_WRITE   = {OP_WRITE, 12'h789};
  localparam logic [15:0] INS_PUSH    = {OP_STACK, 12'h0A5};
  localparam logic [15:0] INS_POP     = {OP_STACK, 12'h1A5};
  localparam logic [15:0] INS_SPEC_RD = {OP_SPECIAL, 12'h034};
  localparam logic [15:0] INS_SPEC_OT = {OP_SPECIAL, 12'h031};

  logic        I_clk = 1'b0;
  logic        I_reset_n;
  logic [15:0] I_instruction;
  logic        I_mem_ready, I_data_ready, I_irq_enabled;
  logic [3:0]  I_irq_req, I_irq_mask;
  logic [8:0]  O_state;
  logic        O_execute, O_push_pc, O_bus_err;
  logic [3:0]  O_irq_ack;
  logic [1:0]  O_irq_num;
  logic [15:0] O_instr;
  logic [OBS_W-1:0] obs;

  int total = 0;
  int bad   = 0;
  logic [OBS_W-1:0] exp_q[$];
  logic [1:0] exp_num;
  logic       exp_push;

  ctrl_seq_unit #(
    .INSTR_W (16), .NUM_IRQ (4), .IRQ_ACK_LAT (2), .STACK_DIR_BIT (8), .MEM_TIMEOUT (8)
  ) dut (
    .I_clk (I_clk), .I_reset_n (I_reset_n), .I_instruction (I_instruction),
    .I_mem_ready (I_mem_ready), .I_data_ready (I_data_ready), .I_irq_enabled (I_irq_enabled),
    .I_irq_req (I_irq_req), .I_irq_mask (I_irq_mask), .O_state (O_state),
    .O_execute (O_execute), .O_push_pc (O_push_pc), .O_irq_ack (O_irq_ack),
    .O_irq_num (O_irq_num), .O_instr (O_instr), .O_bus_err (O_bus_err)
  );

  assign obs = {O_bus_err, O_irq_num, O_irq_ack, O_push_pc, O_execute, O_state};

  // clock
  always #5 I_clk = ~I_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // One cycle: drive inputs, queue the outputs expected after the edge, then compare.
  task automatic cyc(input logic rst_n, input logic mr, input logic dr, input logic [8:0] st,
                     input logic ex, input logic [3:0] ack, input logic err);
    logic [OBS_W-1:0] e;
    logic [OBS_W-1:0] o;
    I_reset_n    = rst_n;
    I_mem_ready  = mr;
    I_data_ready = dr;
    exp_q.push_back({err, exp_num, ack, exp_push, ex, st});
    @(posedge I_clk);
    #1;
    e = exp_q.pop_front();
    o = obs;
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL step%0d observed=%h expected=%h (bus_err,irq_num,irq_ack,push_pc,execute,state)",
             total, o, e);
    end
  endtask

  task automatic chk_instr(input string tag, input logic [15:0] expv);
    total++;
    assert (O_instr === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, O_instr, expv);
    end
  endtask

  // FETCH with a one-cycle strobe and data returned in the following cycle
  task automatic fetch_phase();
    cyc(1, 1, 0, ST_FETCH, 1, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);
    cyc(1, 0, 1, ST_DECODE, 0, 4'b0, 0);
  endtask

  task automatic decode_pass(input logic [15:0] ins);
    I_instruction = ins;
    cyc(1, 0, 0, ST_REG_READ, 0, 4'b0, 0);
    I_instruction = 16'hFFFF;
    cyc(1, 0, 0, ST_EXECUTE, 0, 4'b0, 0);
  endtask

  initial begin
    I_instruction = INS_ADD;
    I_irq_enabled = 1'b0;
    I_irq_req     = 4'b0;
    I_irq_mask    = 4'b0;
    exp_num       = 2'd0;
    exp_push      = 1'b0;

    // reset
    cyc(0, 0, 0, ST_FETCH, 0, 4'b0, 0);
    cyc(0, 1, 1, ST_FETCH, 0, 4'b0, 0);
    chk_instr("reset_instr", 16'h0000);

    // ADD: no memory phase
    fetch_phase();
    decode_pass(INS_ADD);
    cyc(1, 1, 0, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);
    chk_instr("add_instr", INS_ADD);

    // READ: mem_ready must not complete a read
    fetch_phase();
    decode_pass(INS_READ);
    cyc(1, 1, 0, ST_MEM, 1, 4'b0, 0);
    cyc(1, 1, 0, ST_MEM, 0, 4'b0, 0);
    cyc(1, 1, 0, ST_MEM, 0, 4'b0, 0);
    cyc(1, 0, 1, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);
    chk_instr("read_instr", INS_READ);

    // STACK push: memory held off, strobe only when ready, data_ready ignored
    fetch_phase();
    decode_pass(INS_PUSH);
    cyc(1, 0, 0, ST_MEM, 0, 4'b0, 0);
    repeat (3) cyc(1, 0, 0, ST_MEM, 0, 4'b0, 0);
    cyc(1, 1, 0, ST_MEM, 1, 4'b0, 0);
    cyc(1, 1, 0, ST_MEM, 0, 4'b0, 0);
    cyc(1, 0, 1, ST_MEM, 0, 4'b0, 0);
    cyc(1, 1, 0, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);

    // STACK pop is read class; data in the strobe cycle is not a completion
    fetch_phase();
    decode_pass(INS_POP);
    cyc(1, 1, 0, ST_MEM, 1, 4'b0, 0);
    cyc(1, 0, 1, ST_MEM, 0, 4'b0, 0);
    cyc(1, 0, 1, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);

    // SPECIAL read sub-op goes to MEM, other sub-ops do not
    fetch_phase();
    decode_pass(INS_SPEC_RD);
    cyc(1, 1, 0, ST_MEM, 1, 4'b0, 0);
    cyc(1, 1, 0, ST_MEM, 0, 4'b0, 0);
    cyc(1, 0, 1, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);
    fetch_phase();
    decode_pass(INS_SPEC_OT);
    cyc(1, 1, 0, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);

    // WRITE completes on mem_ready
    fetch_phase();
    decode_pass(INS_WRITE);
    cyc(1, 1, 0, ST_MEM, 1, 4'b0, 0);
    cyc(1, 0, 1, ST_MEM, 0, 4'b0, 0);
    cyc(1, 1, 0, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);

    // IRQ: lines 1 and 3 pending, line 1 wins; full save pass then ISR entry
    I_irq_enabled = 1'b1;
    I_irq_req     = 4'b1010;
    I_irq_mask    = 4'b1111;
    fetch_phase();
    decode_pass(INS_ADD);
    cyc(1, 0, 0, ST_REG_WRITE, 0, 4'b0, 0);
    exp_num = 2'd1;
    cyc(1, 0, 0, ST_IRQ_FETCH, 0, 4'b0010, 0);
    I_irq_req = 4'b0000;
    cyc(1, 0, 0, ST_IRQ_FETCH, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_IRQ_SAVE, 0, 4'b0, 0);
    exp_push = 1'b1;
    cyc(1, 0, 0, ST_DECODE, 0, 4'b0, 0);
    decode_pass(INS_PUSH);
    cyc(1, 1, 0, ST_MEM, 1, 4'b0, 0);
    cyc(1, 1, 0, ST_MEM, 0, 4'b0, 0);
    I_irq_req = 4'b1010;
    cyc(1, 1, 0, ST_REG_WRITE, 0, 4'b0, 0);
    exp_push = 1'b0;
    cyc(1, 0, 0, ST_ISR_ENTER, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);

    // Global enable off: pending requests ignored
    I_irq_enabled = 1'b0;
    fetch_phase();
    decode_pass(INS_ADD);
    cyc(1, 0, 0, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);

    // Line 1 masked: line 3 taken; reset lands mid-MEM of the save pass
    I_irq_enabled = 1'b1;
    I_irq_mask    = 4'b1101;
    fetch_phase();
    decode_pass(INS_ADD);
    cyc(1, 0, 0, ST_REG_WRITE, 0, 4'b0, 0);
    exp_num = 2'd3;
    cyc(1, 0, 0, ST_IRQ_FETCH, 0, 4'b1000, 0);
    cyc(1, 0, 0, ST_IRQ_FETCH, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_IRQ_SAVE, 0, 4'b0, 0);
    exp_push = 1'b1;
    cyc(1, 0, 0, ST_DECODE, 0, 4'b0, 0);
    decode_pass(INS_READ);
    cyc(1, 1, 0, ST_MEM, 1, 4'b0, 0);
    cyc(1, 0, 0, ST_MEM, 0, 4'b0, 0);
    exp_push = 1'b0;
    exp_num  = 2'd0;
    cyc(0, 1, 1, ST_FETCH, 0, 4'b0, 0);
    chk_instr("midmem_reset_instr", 16'h0000);
    I_irq_enabled = 1'b0;
    I_irq_req     = 4'b0;
    fetch_phase();
    decode_pass(INS_ADD);
    cyc(1, 0, 0, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);

`ifdef CTRL_SEQ_TIMEOUT_EN
    // FETCH timeout after 8 cycles, then a fresh strobe
    cyc(1, 1, 0, ST_FETCH, 1, 4'b0, 0);
    repeat (7) cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 1);
    cyc(1, 1, 0, ST_FETCH, 1, 4'b0, 0);
    // Completion on the timeout cycle wins
    repeat (7) cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);
    cyc(1, 0, 1, ST_DECODE, 0, 4'b0, 0);
    decode_pass(INS_READ);
    cyc(1, 1, 0, ST_MEM, 1, 4'b0, 0);
    repeat (7) cyc(1, 0, 0, ST_MEM, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 1);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);
`else
    // Without the timeout the fetch waits indefinitely and never flags an error
    cyc(1, 1, 0, ST_FETCH, 1, 4'b0, 0);
    repeat (12) cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);
    cyc(1, 0, 1, ST_DECODE, 0, 4'b0, 0);
    decode_pass(INS_ADD);
    cyc(1, 0, 0, ST_REG_WRITE, 0, 4'b0, 0);
    cyc(1, 0, 0, ST_FETCH, 0, 4'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
